step_input_cond: RTL and testbench



---
 rtl/step_input_cond_if.sv | 39 +++
 rtl/step_input_cond.sv | 175 +++++++++++++++++
 tb/tb_step_input_cond.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_input_cond_if.sv
// step_input_cond_if
//   Groups the raw board-side inputs of the step conditioner and the
//   conditioned outputs that feed the board-level Mealy FSM.
//   Signals:
//     btn_raw  : raw step pushbutton (async, bouncy, active-high)
//     sw_raw   : raw slide switches (async)
//     rpt_en   : raw auto-repeat enable switch (async)
//     ctrl_out : one-cycle step strobe (to FSM ctrl_in)
//     sw_out   : captured switch value (to FSM sw_in)
//     step_cnt : count of strobes issued, wraps 255 -> 0
//   Modports:
//     master : board/stimulus side, drives the raw inputs
//     slave  : conditioner side, drives the conditioned outputs
interface step_input_cond_if;
   logic       btn_raw;
   logic [1:0] sw_raw;
   logic       rpt_en;
   logic       ctrl_out;
   logic [1:0] sw_out;
   logic [7:0] step_cnt;

   modport master (
      output btn_raw,
      output sw_raw,
      output rpt_en,
      input  ctrl_out,
      input  sw_out,
      input  step_cnt
   );

   modport slave (
      input  btn_raw,
      input  sw_raw,
      input  rpt_en,
      output ctrl_out,
      output sw_out,
      output step_cnt
   );
endinterface

// File: rtl/step_input_cond.sv
// step_input_cond
//   Conditions a raw step pushbutton and raw slide switches into the inputs
//   of the board-level Mealy FSM: a debounced one-cycle step strobe, a
//   switch value captured only when the strobe is launched, optional
//   auto-repeat while the button is held, and a strobe counter.
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high reset
//     bus   : step_input_cond_if.slave (raw inputs in, conditioned outputs out)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | button released and accepted as released
//   PRESS_DB   | button seen high, waiting DB_CYCLES stable cycles to accept
//   HELD       | press accepted; counting towards the first auto-repeat
//   REPEAT     | auto-repeating; counting RPT_PERIOD between strobes
//   RELEASE_DB | button seen low, waiting DB_CYCLES stable cycles to accept
module step_input_cond #(
   parameter int DB_CYCLES  = 500000,
   parameter int RPT_DELAY  = 50000000,
   parameter int RPT_PERIOD = 10000000,
   parameter int CNT_W      = 26
) (
   input logic              clk,
   input logic              reset,
   step_input_cond_if.slave bus
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RPT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RPT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PRESS_DB   = 3'd1,
      HELD       = 3'd2,
      REPEAT     = 3'd3,
      RELEASE_DB = 3'd4
   } state_t;

   logic [1:0]       btn_sync;
   logic [1:0]       rpt_sync;
   logic [1:0]       sw_sync1;
   logic [1:0]       sw_sync2;
   logic             btn_s;
   logic             rpt_s;
   logic [1:0]       sw_s;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fire;

   logic             ctrl_q;
   logic [1:0]       sw_q;
   logic [7:0]       step_cnt_q;

   // 2-FF synchronizers; nothing else touches the raw inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_sync <= 2'b00;
         rpt_sync <= 2'b00;
         sw_sync1 <= 2'b00;
         sw_sync2 <= 2'b00;
      end else begin
         btn_sync <= {btn_sync[0], bus.btn_raw};
         rpt_sync <= {rpt_sync[0], bus.rpt_en};
         sw_sync1 <= bus.sw_raw;
         sw_sync2 <= sw_sync1;
      end
   end

   assign btn_s = btn_sync[1];
   assign rpt_s = rpt_sync[1];
   assign sw_s  = sw_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_DB;
               cnt_nxt   = '0;
            end
         end
         PRESS_DB: begin
            if (!btn_s) begin
               state_nxt = IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
               fire      = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nxt = RELEASE_DB;
               cnt_nxt   = '0;
            end else if (rpt_s && (cnt == RD_LAST)) begin
               state_nxt = REPEAT;
               cnt_nxt   = '0;
               fire      = 1'b1;
            end else if (cnt < RD_LAST) begin
               // saturate so a long hold with repeat off never wraps
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         REPEAT: begin
            if (!btn_s) begin
               state_nxt = RELEASE_DB;
               cnt_nxt   = '0;
            end else if (!rpt_s) begin
               // parked at the delay limit: re-enabling repeat fires at once
               state_nxt = HELD;
               cnt_nxt   = RD_LAST;
            end else if (cnt == RP_LAST) begin
               cnt_nxt = '0;
               fire    = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         RELEASE_DB: begin
            if (btn_s) begin
               // release bounce: back to held without a strobe
               state_nxt = HELD;
               cnt_nxt   = RD_LAST;
            end else if (cnt == DB_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q     <= 1'b0;
         sw_q       <= 2'b00;
         step_cnt_q <= 8'd0;
      end else begin
         ctrl_q <= fire;
         if (fire) begin
            sw_q       <= sw_s;
            step_cnt_q <= step_cnt_q + 8'd1;
         end
      end
   end

   assign bus.ctrl_out = ctrl_q;
   assign bus.sw_out   = sw_q;
   assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_step_input_cond.sv
module tb_step_input_cond;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   step_input_cond_if bus ();

   step_input_cond #(
      .DB_CYCLES (DB),
      .RPT_DELAY (RD),
      .RPT_PERIOD(RP),
      .CNT_W     (26)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int fails  = 0;

   // Reference model (repeat disabled): a press is accepted after DB+1
   // consecutive synchronized-high samples while released, a release after
   // DB+1 consecutive synchronized-low samples while pressed.
   logic       hb  [3];
   logic [1:0] hsw [3];
   bit         m_pressed;
   int         m_run1;
   int         m_run0;
   logic       m_ctrl;
   logic [1:0] m_sw;
   logic [7:0] m_cnt;

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         hb[i]  = 1'b0;
         hsw[i] = 2'b00;
      end
      m_pressed = 1'b0;
      m_run1    = 0;
      m_run0    = 0;
      m_ctrl    = 1'b0;
      m_sw      = 2'b00;
      m_cnt     = 8'd0;
   endtask

   // Drive inputs (called just after a rising edge), advance one edge,
   // update the model, and leave time 1 unit past that edge.
   task automatic step(input logic b, input logic [1:0] sw, input logic r);
      logic       s;
      logic [1:0] sws;
      bus.btn_raw = b;
      bus.sw_raw  = sw;
      bus.rpt_en  = r;
      @(posedge clk);
      hb[2]  = hb[1];  hb[1]  = hb[0];  hb[0]  = b;
      hsw[2] = hsw[1]; hsw[1] = hsw[0]; hsw[0] = sw;
      s   = hb[2];
      sws = hsw[2];
      m_ctrl = 1'b0;
      if (!m_pressed) begin
         m_run1 = s ? m_run1 + 1 : 0;
         if (m_run1 == DB + 1) begin
            m_ctrl    = 1'b1;
            m_sw      = sws;
            m_cnt     = m_cnt + 8'd1;
            m_pressed = 1'b1;
            m_run0    = 0;
         end
      end else begin
         m_run0 = s ? 0 : m_run0 + 1;
         if (m_run0 == DB + 1) begin
            m_pressed = 1'b0;
            m_run1    = 0;
         end
      end
      #1;
   endtask

   task automatic do_reset(input logic b);
      bus.btn_raw = b;
      bus.sw_raw  = 2'b00;
      bus.rpt_en  = 1'b0;
      reset       = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int pulses;
      do_reset(1'b0);
      if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== 11'd0) begin
         $display("FAIL reset_values: got ctrl=%b sw=%0d cnt=%0d, want 0/0/0",
                  bus.ctrl_out, bus.sw_out, bus.step_cnt);
         fails++;
      end
      checks++;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 2'b11, 1'b0);
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL reset_press cyc %0d: got ctrl=%b sw=%0d cnt=%0d, want ctrl=%b sw=%0d cnt=%0d",
                     i, bus.ctrl_out, bus.sw_out, bus.step_cnt, m_ctrl, m_sw, m_cnt);
            fails++;
         end
         checks++;
      end
      // outputs are now nonzero (strobe high); reset mid-cycle
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== 11'd0) begin
         $display("FAIL reset_async: got ctrl=%b sw=%0d cnt=%0d, want 0/0/0",
                  bus.ctrl_out, bus.sw_out, bus.step_cnt);
         fails++;
      end
      checks++;
      // button still held across reset: exactly one new strobe afterwards
      @(posedge clk);
      #1;
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 2'b10, 1'b0);
         if (bus.ctrl_out === 1'b1) pulses++;
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL reset_held cyc %0d: got ctrl=%b sw=%0d cnt=%0d, want ctrl=%b sw=%0d cnt=%0d",
                     i, bus.ctrl_out, bus.sw_out, bus.step_cnt, m_ctrl, m_sw, m_cnt);
            fails++;
         end
         checks++;
      end
      if (pulses !== 1 || bus.step_cnt !== 8'd1) begin
         $display("FAIL reset_held_once: got pulses=%0d cnt=%0d, want 1/1", pulses, bus.step_cnt);
         fails++;
      end
      checks++;
   endtask

   task automatic test_clean_press();
      int first;
      int pulses;
      do_reset(1'b0);
      first  = -1;
      pulses = 0;
      for (int i = 0; i < 56; i++) begin
         step(1'b1, 2'b10, 1'b0);
         if (bus.ctrl_out === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL clean_press cyc %0d: got ctrl=%b sw=%0d cnt=%0d, want ctrl=%b sw=%0d cnt=%0d",
                     i, bus.ctrl_out, bus.sw_out, bus.step_cnt, m_ctrl, m_sw, m_cnt);
            fails++;
         end
         checks++;
      end
      if (first !== DB + 2 || pulses !== 1 || bus.sw_out !== 2'd2 || bus.step_cnt !== 8'd1) begin
         $display("FAIL clean_press_summary: got first=%0d pulses=%0d sw=%0d cnt=%0d, want %0d/1/2/1",
                  first, pulses, bus.sw_out, bus.step_cnt, DB + 2);
         fails++;
      end
      checks++;
      for (int i = 0; i < 10; i++) step(1'b0, 2'b10, 1'b0);
   endtask

   task automatic test_bounce();
      int seq_p [5] = '{1, 0, 1, 1, 0};
      int seq_r [5] = '{0, 1, 0, 0, 1};
      do_reset(1'b0);
      for (int i = 0; i < 15; i++) begin
         step((i < 5) ? 1'(seq_p[i]) : 1'b0, 2'b01, 1'b0);
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL bounce_press cyc %0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                     i, bus.ctrl_out, bus.step_cnt, m_ctrl, m_cnt);
            fails++;
         end
         checks++;
      end
      if (bus.step_cnt !== 8'd0) begin
         $display("FAIL bounce_reject: got cnt=%0d, want 0", bus.step_cnt);
         fails++;
      end
      checks++;
      for (int i = 0; i < 25; i++) begin
         if (i < 8)       step(1'b1, 2'b01, 1'b0);
         else if (i < 13) step(1'(seq_r[i-8]), 2'b01, 1'b0);
         else             step(1'b0, 2'b01, 1'b0);
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL bounce_release cyc %0d: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                     i, bus.ctrl_out, bus.step_cnt, m_ctrl, m_cnt);
            fails++;
         end
         checks++;
      end
      if (bus.step_cnt !== 8'd1) begin
         $display("FAIL bounce_release_once: got cnt=%0d, want 1", bus.step_cnt);
         fails++;
      end
      checks++;
   endtask

   task automatic test_switch_isolation();
      do_reset(1'b0);
      for (int i = 0; i < 22; i++) begin
         step(1'b1, (i < 12) ? 2'b01 : 2'b11, 1'b0);
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL sw_hold cyc %0d: got ctrl=%b sw=%0d, want ctrl=%b sw=%0d",
                     i, bus.ctrl_out, bus.sw_out, m_ctrl, m_sw);
            fails++;
         end
         checks++;
      end
      if (bus.sw_out !== 2'd1) begin
         $display("FAIL sw_isolated: got sw=%0d, want 1", bus.sw_out);
         fails++;
      end
      checks++;
      for (int i = 0; i < 20; i++) begin
         step((i >= 10), 2'b11, 1'b0);
         if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
            $display("FAIL sw_next cyc %0d: got ctrl=%b sw=%0d, want ctrl=%b sw=%0d",
                     i, bus.ctrl_out, bus.sw_out, m_ctrl, m_sw);
            fails++;
         end
         checks++;
      end
      if (bus.sw_out !== 2'd3 || bus.step_cnt !== 8'd2) begin
         $display("FAIL sw_updated: got sw=%0d cnt=%0d, want 3/2", bus.sw_out, bus.step_cnt);
         fails++;
      end
      checks++;
   endtask

   // Repeat timing is checked against pulse times derived directly from the
   // parameters: first at DB+2, then +RPT_DELAY, then every RPT_PERIOD.
   task automatic test_auto_repeat();
      int got [$];
      int exp [$];
      int t;
      logic prev;
      do_reset(1'b0);
      t = DB + 2;
      exp.push_back(t);
      t = t + RD;
      // rpt_en dropped before edge 40 reaches the FSM at edge 42
      while (t <= 41) begin
         exp.push_back(t);
         t = t + RP;
      end
      prev = 1'b0;
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 2'b01, (i < 40));
         if (bus.ctrl_out === 1'b1) begin
            got.push_back(i);
            if (prev === 1'b1) begin
               $display("FAIL repeat_width cyc %0d: got ctrl high twice in a row, want single-cycle", i);
               fails++;
            end
            checks++;
         end
         prev = bus.ctrl_out;
      end
      if (got.size() !== exp.size()) begin
         $display("FAIL repeat_count: got %0d pulses, want %0d", got.size(), exp.size());
         fails++;
      end
      checks++;
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         if (got[i] !== exp[i]) begin
            $display("FAIL repeat_time #%0d: got cycle %0d, want %0d", i, got[i], exp[i]);
            fails++;
         end
         checks++;
      end
      if (bus.step_cnt !== 8'(exp.size()) || bus.sw_out !== 2'd1) begin
         $display("FAIL repeat_state: got cnt=%0d sw=%0d, want %0d/1",
                  bus.step_cnt, bus.sw_out, exp.size());
         fails++;
      end
      checks++;
      for (int i = 0; i < 10; i++) step(1'b0, 2'b01, 1'b0);
   endtask

   task automatic test_wrap();
      int pulses;
      logic prev;
      do_reset(1'b0);
      pulses = 0;
      prev   = 1'b0;
      for (int p = 0; p < 256; p++) begin
         for (int i = 0; i < 12; i++) begin
            step((i < 6), 2'(p % 4), 1'b0);
            if (bus.ctrl_out === 1'b1) pulses++;
            if ((prev === 1'b1 && bus.ctrl_out === 1'b1) ||
                {bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
               $display("FAIL wrap p%0d c%0d: got ctrl=%b sw=%0d cnt=%0d, want ctrl=%b sw=%0d cnt=%0d",
                        p, i, bus.ctrl_out, bus.sw_out, bus.step_cnt, m_ctrl, m_sw, m_cnt);
               fails++;
            end
            checks++;
            prev = bus.ctrl_out;
         end
      end
      if (pulses !== 256 || bus.step_cnt !== 8'd0) begin
         $display("FAIL wrap_total: got pulses=%0d cnt=%0d, want 256/0", pulses, bus.step_cnt);
         fails++;
      end
      checks++;
   endtask

   task automatic test_random();
      logic lvl;
      int   len;
      do_reset(1'b0);
      for (int seg = 0; seg < 120; seg++) begin
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         for (int j = 0; j < len; j++) begin
            step(lvl, 2'($urandom_range(0, 3)), 1'b0);
            if ({bus.ctrl_out, bus.sw_out, bus.step_cnt} !== {m_ctrl, m_sw, m_cnt}) begin
               $display("FAIL random seg %0d: got ctrl=%b sw=%0d cnt=%0d, want ctrl=%b sw=%0d cnt=%0d",
                        seg, bus.ctrl_out, bus.sw_out, bus.step_cnt, m_ctrl, m_sw, m_cnt);
               fails++;
            end
            checks++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_switch_isolation();
      test_auto_repeat();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
